// File: rtl/traffic_signal_safety_monitor_if.sv
// rtl/traffic_signal_safety_monitor_if.sv - lamp command/driver bundle between controller, monitor and lamp drivers
interface traffic_signal_safety_monitor_if;
  logic [1:0] TL1;
  logic [1:0] TL2;
  logic [1:0] TL3;
  logic [1:0] TL4;
  logic       fault_clr;
  logic [1:0] SIG1;
  logic [1:0] SIG2;
  logic [1:0] SIG3;
  logic [1:0] SIG4;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output TL1, TL2, TL3, TL4, fault_clr,
    input  SIG1, SIG2, SIG3, SIG4, fault, fault_code
  );

  modport slave (
    input  TL1, TL2, TL3, TL4, fault_clr,
    output SIG1, SIG2, SIG3, SIG4, fault, fault_code
  );
endinterface

// File: rtl/traffic_signal_safety_monitor.sv
// rtl/traffic_signal_safety_monitor.sv - passes legal lamp commands through, latches first fault and flashes red
module traffic_signal_safety_monitor #(
  parameter int MIN_YELLOW  = 2,
  parameter int MAX_GREEN   = 16,
  parameter int FLASH_HALF  = 4,
  parameter int ALLOW_PAIRS = 0
) (
  input logic clk,
  input logic rst,
  traffic_signal_safety_monitor_if.slave bus
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int GW = $clog2(MAX_GREEN + 2);
  localparam int FW = $clog2(2 * FLASH_HALF);

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;
  localparam logic [1:0] L_BAD = 2'b11;

  typedef enum logic {ST_MON, ST_FAULT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      w_tl    [4];
  logic [1:0]      r_prev  [4];
  logic [YW-1:0]   r_ycnt  [4];
  logic [GW-1:0]   r_gcnt  [4];
  logic [1:0]      r_sig   [4];
  logic [2:0]      r_code;
  logic [FW-1:0]   r_flash;
  logic [FW-1:0]   w_flash_nxt;
  logic [3:0]      w_nonred;
  logic            w_inv, w_conf, w_trans, w_short, w_wd;
  logic [2:0]      w_code;
  logic            w_clear;

  assign w_tl[0] = bus.TL1;
  assign w_tl[1] = bus.TL2;
  assign w_tl[2] = bus.TL3;
  assign w_tl[3] = bus.TL4;

  always_comb begin
    w_nonred = '0;
    w_inv    = 1'b0;
    w_trans  = 1'b0;
    w_short  = 1'b0;
    w_wd     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_nonred[i] = (w_tl[i] != L_RED);
      w_inv   |= (w_tl[i] == L_BAD);
      w_trans |= (r_prev[i] == L_RED && w_tl[i] == L_YEL) ||
                 (r_prev[i] == L_GRN && w_tl[i] == L_RED) ||
                 (r_prev[i] == L_YEL && w_tl[i] == L_GRN);
      w_short |= (r_prev[i] == L_YEL && w_tl[i] == L_RED && r_ycnt[i] < YW'(MIN_YELLOW));
      w_wd    |= (r_prev[i] == L_GRN && w_tl[i] == L_GRN && r_gcnt[i] == GW'(MAX_GREEN));
    end
    // Paired mode: {1,3} and {2,4} are compatible, any mix across groups conflicts.
    if (ALLOW_PAIRS != 0)
      w_conf = (w_nonred[0] | w_nonred[2]) & (w_nonred[1] | w_nonred[3]);
    else
      w_conf = ($countones(w_nonred) > 1);
    if (w_inv)        w_code = 3'd1;
    else if (w_conf)  w_code = 3'd2;
    else if (w_trans) w_code = 3'd3;
    else if (w_short) w_code = 3'd4;
    else if (w_wd)    w_code = 3'd5;
    else              w_code = 3'd0;
    w_clear     = bus.fault_clr && (w_nonred == 4'b0000);
    w_flash_nxt = (r_flash == FW'(2 * FLASH_HALF - 1)) ? '0 : r_flash + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_MON:   if (w_code != 3'd0) w_state_nxt = ST_FAULT;
      ST_FAULT: if (w_clear)        w_state_nxt = ST_MON;
      default:  w_state_nxt = ST_MON;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_MON;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_FAULT && w_clear)) begin
      r_code  <= 3'd0;
      r_flash <= '0;
      for (int i = 0; i < 4; i++) begin
        r_sig[i]  <= L_RED;
        r_prev[i] <= L_RED;
        r_ycnt[i] <= '0;
        r_gcnt[i] <= '0;
      end
    end else if (r_state == ST_MON) begin
      if (w_code != 3'd0) begin
        r_code  <= w_code;
        r_flash <= '0;
        for (int i = 0; i < 4; i++) r_sig[i] <= L_RED;
      end else begin
        for (int i = 0; i < 4; i++) begin
          r_sig[i]  <= w_tl[i];
          r_prev[i] <= w_tl[i];
          if (w_tl[i] == L_YEL)
            r_ycnt[i] <= (r_ycnt[i] == YW'(MIN_YELLOW)) ? r_ycnt[i] : r_ycnt[i] + 1'b1;
          else
            r_ycnt[i] <= '0;
          if (w_tl[i] == L_GRN)
            r_gcnt[i] <= (r_gcnt[i] == GW'(MAX_GREEN + 1)) ? r_gcnt[i] : r_gcnt[i] + 1'b1;
          else
            r_gcnt[i] <= '0;
        end
      end
    end else begin
      // Entry cycle was flash count 0 (red); first FLASH_HALF counts red, rest dark.
      r_flash <= w_flash_nxt;
      for (int i = 0; i < 4; i++)
        r_sig[i] <= (w_flash_nxt < FW'(FLASH_HALF)) ? L_RED : 2'b11;
    end
  end

  assign bus.SIG1       = r_sig[0];
  assign bus.SIG2       = r_sig[1];
  assign bus.SIG3       = r_sig[2];
  assign bus.SIG4       = r_sig[3];
  assign bus.fault      = (r_state == ST_FAULT);
  assign bus.fault_code = r_code;

endmodule

// File: tb/tb_traffic_signal_safety_monitor.sv
// tb/tb_traffic_signal_safety_monitor.sv - directed scoreboard bench for traffic_signal_safety_monitor
module tb_traffic_signal_safety_monitor;
  localparam int FH = 4;

  typedef struct packed {
    logic [7:0] sig;
    logic       flt;
    logic [2:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  traffic_signal_safety_monitor_if u_if ();
  traffic_signal_safety_monitor_if u_if2 ();

  traffic_signal_safety_monitor #(.ALLOW_PAIRS(0)) u_dut (
    .clk(clk), .rst(rst), .bus(u_if.slave)
  );

  traffic_signal_safety_monitor #(.ALLOW_PAIRS(1)) u_dut2 (
    .clk(clk), .rst(rst), .bus(u_if2.slave)
  );

  function automatic exp_t obs1();
    return {u_if.SIG1, u_if.SIG2, u_if.SIG3, u_if.SIG4, u_if.fault, u_if.fault_code};
  endfunction

  function automatic exp_t obs2();
    return {u_if2.SIG1, u_if2.SIG2, u_if2.SIG3, u_if2.SIG4, u_if2.fault, u_if2.fault_code};
  endfunction

  function automatic logic [7:0] flash_sig(input int k);
    return ((k % (2 * FH)) < FH) ? 8'h00 : 8'hFF;
  endfunction

  function automatic void cmp(input string tag, input exp_t o, input exp_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed sig=%h fault=%b code=%0d expected sig=%h fault=%b code=%0d",
             tag, o.sig, o.flt, o.code, e.sig, e.flt, e.code);
    end
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (q1.size() > 0) cmp(tag, obs1(), q1.pop_front());
    if (q2.size() > 0) cmp({tag, "_pair"}, obs2(), q2.pop_front());
  endtask

  task automatic step(input logic [1:0] a, b, c, d, input logic clr,
                      input logic [7:0] esig, input logic ef, input logic [2:0] ec,
                      input string tag);
    @(negedge clk);
    u_if.TL1 = a; u_if.TL2 = b; u_if.TL3 = c; u_if.TL4 = d;
    u_if.fault_clr = clr;
    q1.push_back({esig, ef, ec});
    tick(tag);
  endtask

  task automatic pass(input logic [1:0] a, b, c, d, input string tag);
    step(a, b, c, d, 1'b0, {a, b, c, d}, 1'b0, 3'd0, tag);
  endtask

  task automatic step2(input logic [1:0] a, b, c, d,
                       input logic [7:0] esig, input logic ef, input logic [2:0] ec,
                       input string tag);
    @(negedge clk);
    u_if2.TL1 = a; u_if2.TL2 = b; u_if2.TL3 = c; u_if2.TL4 = d;
    q2.push_back({esig, ef, ec});
    tick(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    u_if.TL1 = 2'b00; u_if.TL2 = 2'b00; u_if.TL3 = 2'b00; u_if.TL4 = 2'b00;
    u_if.fault_clr = 1'b1;
    u_if2.TL1 = 2'b00; u_if2.TL2 = 2'b00; u_if2.TL3 = 2'b00; u_if2.TL4 = 2'b00;
    u_if2.fault_clr = 1'b0;
    q1.push_back({8'h00, 1'b0, 3'd0});
    q2.push_back({8'h00, 1'b0, 3'd0});
    tick(tag);
    rst = 1'b0;
    u_if.fault_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset("reset");

    // Paired mode on the second instance: 1/3 together legal, adding lane 4 conflicts
    repeat (3) step2(2'd2, 2'd0, 2'd2, 2'd0, {2'd2, 2'd0, 2'd2, 2'd0}, 1'b0, 3'd0, "pairs_ok");
    step2(2'd2, 2'd0, 2'd2, 2'd2, 8'h00, 1'b1, 3'd2, "pairs_conflict");
    step2(2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 3'd2, "pairs_hold");

    repeat (5) pass(2'd2, 2'd0, 2'd0, 2'd0, "legal_green");
    repeat (2) pass(2'd1, 2'd0, 2'd0, 2'd0, "legal_yellow");
    pass(2'd0, 2'd0, 2'd0, 2'd0, "legal_red");

    step(2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 3'd2, "conflict");
    for (int k = 1; k <= 9; k++)
      step(2'd0, 2'd0, 2'd0, (k == 1) ? 2'd3 : 2'd0, 1'b0, flash_sig(k), 1'b1, 3'd2, "flash");
    step(2'd2, 2'd0, 2'd0, 2'd0, 1'b1, flash_sig(10), 1'b1, 3'd2, "clr_ignored");
    step(2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0, 3'd0, "clear");
    pass(2'd2, 2'd0, 2'd0, 2'd0, "post_clear_green");
    repeat (2) pass(2'd1, 2'd0, 2'd0, 2'd0, "post_clear_yellow");
    pass(2'd0, 2'd0, 2'd0, 2'd0, "post_clear_red");

    repeat (3) pass(2'd0, 2'd2, 2'd0, 2'd0, "tl2_green");
    step(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 3'd3, "green_to_red");
    step(2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0, 3'd0, "clear_trans");

    pass(2'd0, 2'd2, 2'd0, 2'd0, "tl2_green_b");
    pass(2'd0, 2'd1, 2'd0, 2'd0, "tl2_yellow_once");
    step(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 3'd4, "short_yellow");
    step(2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0, 3'd0, "clear_short");

    repeat (16) pass(2'd0, 2'd0, 2'd2, 2'd0, "green16");
    repeat (2) pass(2'd0, 2'd0, 2'd1, 2'd0, "green16_yellow");
    pass(2'd0, 2'd0, 2'd0, 2'd0, "green16_red");
    repeat (16) pass(2'd0, 2'd0, 2'd2, 2'd0, "green17_pre");
    step(2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 8'h00, 1'b1, 3'd5, "watchdog");
    step(2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0, 3'd0, "clear_wd");

    step(2'd2, 2'd2, 2'd0, 2'd3, 1'b0, 8'h00, 1'b1, 3'd1, "priority");
    for (int k = 1; k <= 5; k++)
      step(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, flash_sig(k), 1'b1, 3'd1, "flash_prio");
    do_reset("rst_mid_flash");
    pass(2'd0, 2'd0, 2'd0, 2'd2, "post_reset_green");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/traffic_signal_safety_monitor.md
Name: traffic_signal_safety_monitor

Overview:
- Downstream of smart_traffic_controller. Consumes its four 2-bit lamp commands TL1..TL4 and drives the lamp-driver outputs SIG1..SIG4.
- Registers the commands through unchanged while they are legal.
- On any safety violation it latches a fault code and forces all lamps to flashing red until an operator clear.
- A violating command never reaches SIGn.

Parameters:
- MIN_YELLOW, 2: minimum consecutive yellow cycles required before yellow→red.
- MAX_GREEN, 16: maximum consecutive green cycles per lane.
- FLASH_HALF, 4: cycles per half-period of the fault flash.
- ALLOW_PAIRS, 0: 1 = TL1/TL3 and TL2/TL4 may be non-red at the same time; 0 = at most one lane non-red.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- TL1..TL4  in  2 each  controller lamp commands: 00 red, 01 yellow, 10 green, 11 invalid.
- fault_clr  in  1  operator clear request, level-sampled.
- SIG1..SIG4  out  2 each  lamp-driver outputs, registered: 00 red, 01 yellow, 10 green, 11 dark.
- fault  out  1  latched fault flag.
- fault_code  out  3  first-fault cause; 0 = none.

Behaviour:
- Reset (rst=1 at an edge), all registered:
  - SIGn=00, fault=0, fault_code=0.
  - Per-lane previous-state registers = red.
  - Yellow/green counters = 0; flash counter = 0.
  - rst overrides fault_clr and any in-progress fault.
- Monitoring mode (fault=0): each edge evaluates the current TL inputs against the per-lane history.
  - No violation: SIGn<=TLn (1-cycle latency); update history and counters.
  - Violation: fault<=1, fault_code<=cause, SIGn<=00 in the same edge.
- Checks (codes):
  - 1 invalid: any TLn=11.
  - 2 conflict:
    - ALLOW_PAIRS=0: more than one TLn≠00.
    - ALLOW_PAIRS=1: any non-red lane whose cross pair is also non-red; pairs are {1,3} and {2,4}.
  - 3 illegal transition.
    - Legal: R→R, R→G, G→G, G→Y, Y→Y, Y→R.
    - Illegal: G→R, R→Y, Y→G.
  - 4 short yellow: Y→R when that lane's yellow count < MIN_YELLOW.
  - 5 green watchdog: lane green for its (MAX_GREEN+1)-th consecutive cycle.
- Simultaneous violations: the lowest code wins (1 highest priority). Lane order does not matter.
- Counters (per lane):
  - Yellow count: =1 on the first yellow cycle, +1 per further yellow cycle, saturating at MIN_YELLOW; cleared when the lane is non-yellow.
  - Green count: same scheme, saturating at MAX_GREEN+1.
  - Widths: $clog2 of (saturation value + 1).
- Fault mode (fault=1):
  - Checks, history and lane counters are frozen; fault_code is held.
  - Flash counter runs from 0 at fault entry.
  - All SIGn=00 for FLASH_HALF cycles, then 11 for FLASH_HALF cycles, repeating.
  - The fault-entry cycle counts as the first red cycle.
- Clear:
  - fault_clr=1 with fault=1 and all TLn=00 at an edge → fault<=0, fault_code<=0, SIGn<=00, history=red, all counters=0. Monitoring resumes at the next edge.
  - fault_clr with any TLn≠00 is ignored; the fault stays.
  - fault_clr with fault=0 has no effect.
- A second violation while faulted is not recorded.

Test Plan:
- Reset, then legal cycle on TL1 (R→G for 5 cycles, G→Y for 2, Y→R), others 00 → SIG1 follows TL1 one cycle late; fault=0 throughout.
- TL1=10 and TL2=10 in the same cycle with ALLOW_PAIRS=0 → next edge fault=1, fault_code=2; SIG=00 for 4 cycles, then 11 for 4, repeating. With ALLOW_PAIRS=1, TL1=TL3=10 causes no fault.
- TL2: R→G for 3 cycles, then G→R directly → fault_code=3. TL2 yellow for 1 cycle then red → fault_code=4.
- TL3 green for 17 consecutive cycles → fault on the 17th input cycle, fault_code=5. Green for exactly 16 cycles then yellow → no fault.
- In the same cycle TL4=11 and TL1=TL2=10 → fault_code=1 (priority).
- While faulted:
  - fault_clr=1 with TL1=10 → still faulted.
  - All TL=00 with fault_clr=1 → fault=0, code=0, SIGn=00; a following legal R→G passes through.
- Assert rst mid-flash → SIGn=00, fault=0 at the next edge.
